// File: rtl/pos_disp_pkg.sv
// Shared constants and state encoding for the position readout.
//   NUM_DIGITS : number of multiplexed 7-segment digits
//   BCD_MAX    : largest displayable value; larger inputs saturate to it
//   AN_ALL_OFF : anode pattern with every digit dark (anodes are active-low)
//   conv_state_e : binary-to-BCD conversion FSM states
package pos_disp_pkg;

   localparam int          NUM_DIGITS = 4;
   localparam logic [13:0] BCD_MAX    = 14'd9999;
   localparam logic [3:0]  AN_ALL_OFF = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } conv_state_e;

endpackage

// File: rtl/dd_bin2bcd.sv
// Sequential shift-add-3 binary-to-BCD converter, free-running.
// Every 16 cycles it samples num_i, saturates it to 9999 and publishes
// a four-digit BCD result.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   num_i  : unsigned value to convert (IN_W >= 14)
//   bcd_o  : last committed BCD result, stable between commits
//   ovf_o  : set when the committed result was saturated
//   upd_o  : one-cycle pulse in the cycle a new result becomes visible
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | sample and saturate input, clear accumulator (1 cycle)
// ST_SHIFT | adjust nibbles >= 5 by +3, shift left; 14 iterations
// ST_DONE  | result visible on bcd_o/ovf_o, upd_o pulses (1 cycle)
module dd_bin2bcd
   import pos_disp_pkg::*;
#(
   parameter int IN_W = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [IN_W-1:0] num_i,
   output logic [15:0]     bcd_o,
   output logic            ovf_o,
   output logic            upd_o
);

   localparam logic [IN_W-1:0] MAX_IN = IN_W'(BCD_MAX);

   conv_state_e state_q, state_d;
   logic [13:0] sr_q, sr_d;
   logic [15:0] acc_q, acc_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        flag_q, flag_d;
   logic [15:0] bcd_q, bcd_d;
   logic        ovf_q, ovf_d;

   logic        in_ovf;
   logic [13:0] sat;
   logic [15:0] acc_adj;
   logic [29:0] shifted;

   assign in_ovf = (num_i > MAX_IN);
   assign sat    = in_ovf ? BCD_MAX : num_i[13:0];

   always_comb begin
      acc_adj = acc_q;
      for (int k = 0; k < 4; k++) begin
         if (acc_q[4*k +: 4] >= 4'd5) begin
            acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
         end
      end
   end

   assign shifted = {acc_adj, sr_q} << 1;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      flag_d  = flag_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      upd_o   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            sr_d    = sat;
            flag_d  = in_ovf;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            acc_d = shifted[29:14];
            sr_d  = shifted[13:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd13) begin
               // Commit on the final shift so the result and its flag are
               // already visible during the DONE cycle alongside upd_o.
               bcd_d   = shifted[29:14];
               ovf_d   = flag_q;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            upd_o   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         flag_q  <= 1'b0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         flag_q  <= flag_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bcd_o = bcd_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/pos_bcd_scan.sv
// Four-digit decimal readout of the box position for the 7-segment display.
// Converts num_in_i to BCD continuously and scans the digits onto the
// active-low anodes, one digit per scan tick.
//   clk_i    : system clock (CLK_HZ)
//   rst_i    : synchronous active-high reset
//   num_in_i : unsigned position to display
//   digit_o  : BCD nibble of the currently enabled digit
//   an_o     : anode enables, active-low, bit 0 = ones digit
//   ovf_o    : displayed value was saturated to 9999
//   upd_o    : one-cycle pulse when a new result is committed
// Build option: define POS_BCD_SCAN_LZB_EN for leading-zero blanking.
module pos_bcd_scan
   import pos_disp_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int SCAN_HZ = 1000,
   parameter int IN_W    = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [IN_W-1:0] num_in_i,
   output logic [3:0]      digit_o,
   output logic [3:0]      an_o,
   output logic            ovf_o,
   output logic            upd_o
);

   localparam int               DIV    = CLK_HZ / SCAN_HZ;
   localparam int               DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(DIV - 1);
   localparam int               IDX_W  = $clog2(NUM_DIGITS);

   logic [15:0]      bcd;
   logic [DIV_W-1:0] div_q, div_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [3:0]       an_q, an_d;
   logic [3:0]       digit_q, digit_d;
   logic             tick;

   dd_bin2bcd #(.IN_W(IN_W)) u_bin2bcd (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .num_i (num_in_i),
      .bcd_o (bcd),
      .ovf_o (ovf_o),
      .upd_o (upd_o)
   );

   assign tick = (div_q == DIV_TC);

   always_comb begin
      div_d   = tick ? '0 : div_q + 1'b1;
      idx_d   = idx_q;
      an_d    = an_q;
      digit_d = digit_q;
      if (tick) begin
         idx_d   = idx_q + 1'b1;
         an_d    = ~(4'b0001 << idx_d);
         digit_d = bcd[{idx_d, 2'b00} +: 4];
`ifdef POS_BCD_SCAN_LZB_EN
         // Digit k is dark when it and every digit above it are zero.
         if ((idx_d != '0) && ((bcd >> {idx_d, 2'b00}) == 16'd0)) begin
            an_d = AN_ALL_OFF;
         end
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q   <= '0;
         idx_q   <= '0;
         an_q    <= AN_ALL_OFF;
         digit_q <= '0;
      end else begin
         div_q   <= div_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         digit_q <= digit_d;
      end
   end

   assign an_o    = an_q;
   assign digit_o = digit_q;

endmodule

// File: doc/pos_bcd_scan.md
# pos_bcd_scan

Four-digit decimal position readout for the Nexys 7-segment display: samples the 16-bit box position driven by the VGA box-motion logic, converts it to BCD with a sequential shift-add-3 engine, and time-multiplexes the four digits onto the anode lines. It sits directly downstream of the box-position registers. It feeds the existing binary-to-segment decoder, which turns the `digit` nibble into cathode patterns.

## Interface
Parameters:
- CLK_HZ, 100_000_000: input clock frequency.
- SCAN_HZ, 1000: digit-advance rate. Full refresh is SCAN_HZ/4.
- IN_W, 16: width of `num_in`.

Ports:
- clk  in  1  100 MHz system clock. The block uses a single clock domain.
- rst  in  1  reset. Synchronous, active-high.
- num_in  in  IN_W  unsigned position to display.
- digit  out  4  BCD nibble for the currently enabled digit.
- an  out  4  anode enables, active-low, one-hot-low. Bit 0 is the rightmost (ones) digit.
- ovf  out  1  high while the displayed value was saturated.
- upd  out  1  one-cycle pulse when a new conversion result is committed.

## Operation
- Conversion FSM: IDLE → SHIFT → DONE → IDLE. It runs back-to-back continuously.
  - IDLE (1 cycle):
    - Latch `sat = (num_in > 9999) ? 9999 : num_in` into a 14-bit shift register.
    - Latch the overflow flag.
    - Clear the 16-bit BCD accumulator.
  - SHIFT (exactly 14 cycles):
    - Each cycle, add 3 to every accumulator nibble that is ≥5.
    - Then shift {accumulator, shift register} left by 1.
    - A 4-bit iteration counter counts 0..13 and exits on 13.
  - DONE (1 cycle):
    - Copy the accumulator to display register `bcd_q` and the flag to `ovf`.
    - Pulse `upd`.
- Sample-to-commit period: 16 cycles, fixed, independent of the value. `num_in` changing during SHIFT does not affect the conversion in flight.
- `bcd_q` changes only in DONE, so the scan logic never sees a partial result.
- Scan divider: counter `0..CLK_HZ/SCAN_HZ-1` (default 99_999). `tick` is asserted when the counter equals its terminal count, and the counter wraps to 0.
- Digit index `idx` (2 bits): increments on `tick` and wraps 3→0.
- Outputs for index `idx`:
  - `an` = ~(1<<idx).
  - `digit` = `bcd_q[4*idx+3 : 4*idx]`.
- Values above 9999 display 9999 with `ovf`=1. This covers position underflow wrap, e.g. 65533 → 9999.

## Timing
- Reset values:
  - `an`=4'b1111, `digit`=0, `ovf`=0, `upd`=0.
  - `bcd_q`=0, `idx`=0, divider=0, FSM=IDLE.
- First conversion:
  - IDLE is on the first cycle after `rst` deasserts.
  - `upd` is high on cycle 16, counting the IDLE cycle as cycle 1.
- First `tick`: CLK_HZ/SCAN_HZ cycles after reset release.
- `an`/`digit` are registered and update on the cycle after `tick`.
  - The first scan cycle lights digit 1 (`an`=4'b1101).
  - `an` stays 4'b1111 until the first `tick`.
- `rst` asserted mid-SHIFT aborts the conversion. `bcd_q` returns to 0 and the result is not committed.
- Concurrent `tick` and DONE: the scan uses the newly committed `bcd_q` from the following cycle. No glitch rule is needed.

## Configuration
- Macro: `POS_BCD_SCAN_LZB_EN`.
- Defined (leading-zero blanking):
  - Digit k > 0 has its `an` bit forced to 1 when nibbles k..3 of `bcd_q` are all zero.
  - A value of 0 shows a single "0" on digit 0.
  - `digit` still carries the nibble.
- Undefined: all four digits are always enabled in turn, with leading zeros shown.

## Structure
- Package `pos_disp_pkg`:
  - NUM_DIGITS=4, BCD_MAX=14'd9999, AN_ALL_OFF=4'b1111.
  - FSM state encoding (IDLE, SHIFT, DONE).
- Sub-module `dd_bin2bcd`: the conversion FSM (IDLE/SHIFT/DONE, saturation, `upd`).
- Top-level `pos_bcd_scan`: divider, digit index, output mux and blanking.

## Test plan
- Reset, then `num_in`=320:
  - `upd` on cycle 16 with `bcd_q`=16'h0320 and `ovf`=0.
  - After successive ticks, `an` walks 1101, 1011, 0111, 1110 with `digit` 2, 3, 0, 0.
- `num_in`=65533 → `bcd_q`=16'h9999 and `ovf`=1. Then `num_in`=9999 → `ovf`=0 with `bcd_q` unchanged.
- Change `num_in` 240→241 mid-SHIFT → the committed value is 0240. The next commit, 16 cycles later, is 0241.
- Assert `rst` for 1 cycle at SHIFT iteration 7 → the next cycle shows `an`=1111, `digit`=0, `bcd_q`=0, and no `upd`. A fresh conversion completes 16 cycles after release.
- With CLK_HZ/SCAN_HZ overridden to 8 → the first `tick` falls 8 cycles after reset release (7 cycles after IDLE). `idx` wraps 3→0 every 32 cycles.
- `POS_BCD_SCAN_LZB_EN` defined:
  - `num_in`=7 → only `an`=1110 is ever asserted.
  - `num_in`=0 → digit 0 shows 0.
  - `num_in`=1005 → all four digits enabled.
